// File: rtl/regfile_rename.sv
// Architectural register file with rename table: committed values plus per-register
// busy bit and youngest in-flight ROB tag, with commit bypass on decode lookups.
module regfile_rename #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned REG_BITS = 5,
  parameter int unsigned ROB_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                flush,
  input  logic [REG_BITS-1:0] rs1,
  input  logic [REG_BITS-1:0] rs2,
  output logic                rs1_busy,
  output logic                rs2_busy,
  output logic [XLEN-1:0]     rs1_val,
  output logic [XLEN-1:0]     rs2_val,
  output logic [ROB_BITS-1:0] rs1_tag,
  output logic [ROB_BITS-1:0] rs2_tag,
  input  logic                upd_flag,
  input  logic [ROB_BITS-1:0] upd_idx,
  input  logic [REG_BITS-1:0] upd_rd,
  input  logic                write_flag,
  input  logic [ROB_BITS-1:0] write_idx,
  input  logic [REG_BITS-1:0] write_rd,
  input  logic [XLEN-1:0]     new_val
);

  localparam int unsigned NumRegs = 1 << REG_BITS;

  logic [NumRegs-1:0][XLEN-1:0]     val_q;
  logic [NumRegs-1:0]               busy_q;
  logic [NumRegs-1:0][ROB_BITS-1:0] tag_q;

  logic commit_en;
  logic rename_en;

  assign commit_en = write_flag && (write_rd != '0);
  assign rename_en = upd_flag && (upd_rd != '0) && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      val_q  <= '0;
      busy_q <= '0;
      tag_q  <= '0;
    end else if (rdy) begin
      if (commit_en) begin
        val_q[write_rd] <= new_val;
        if (tag_q[write_rd] == write_idx) begin
          busy_q[write_rd] <= 1'b0;
        end
      end
      // Later assignments win: flush beats everything, rename beats the commit clear.
      if (flush) begin
        busy_q <= '0;
      end else if (rename_en) begin
        busy_q[upd_rd] <= 1'b1;
        tag_q[upd_rd]  <= upd_idx;
      end
    end
  end

  always_comb begin
    rs1_busy = 1'b0;
    rs1_val  = '0;
    rs1_tag  = '0;
    if (rs1 != '0) begin
      rs1_busy = busy_q[rs1];
      rs1_val  = val_q[rs1];
      rs1_tag  = tag_q[rs1];
      if (write_flag && (write_rd == rs1) && busy_q[rs1] && (tag_q[rs1] == write_idx)) begin
        rs1_busy = 1'b0;
        rs1_val  = new_val;
      end
    end
  end

  always_comb begin
    rs2_busy = 1'b0;
    rs2_val  = '0;
    rs2_tag  = '0;
    if (rs2 != '0) begin
      rs2_busy = busy_q[rs2];
      rs2_val  = val_q[rs2];
      rs2_tag  = tag_q[rs2];
      if (write_flag && (write_rd == rs2) && busy_q[rs2] && (tag_q[rs2] == write_idx)) begin
        rs2_busy = 1'b0;
        rs2_val  = new_val;
      end
    end
  end

endmodule

// File: tb/tb_regfile_rename.sv
// Directed bench for regfile_rename: rename, commit bypass, tag ownership, flush, x0 and rdy.
module tb_regfile_rename;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        flush;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        rs1_busy;
  logic        rs2_busy;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [3:0]  rs1_tag;
  logic [3:0]  rs2_tag;
  logic        upd_flag;
  logic [3:0]  upd_idx;
  logic [4:0]  upd_rd;
  logic        write_flag;
  logic [3:0]  write_idx;
  logic [4:0]  write_rd;
  logic [31:0] new_val;

  int checks = 0;
  int errors = 0;

  regfile_rename dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .flush      (flush),
    .rs1        (rs1),
    .rs2        (rs2),
    .rs1_busy   (rs1_busy),
    .rs2_busy   (rs2_busy),
    .rs1_val    (rs1_val),
    .rs2_val    (rs2_val),
    .rs1_tag    (rs1_tag),
    .rs2_tag    (rs2_tag),
    .upd_flag   (upd_flag),
    .upd_idx    (upd_idx),
    .upd_rd     (upd_rd),
    .write_flag (write_flag),
    .write_idx  (write_idx),
    .write_rd   (write_rd),
    .new_val    (new_val)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush      = 1'b0;
    upd_flag   = 1'b0;
    upd_idx    = '0;
    upd_rd     = '0;
    write_flag = 1'b0;
    write_idx  = '0;
    write_rd   = '0;
    new_val    = '0;
  endtask

  task automatic rename(input logic [4:0] rd, input logic [3:0] idx);
    upd_flag = 1'b1;
    upd_rd   = rd;
    upd_idx  = idx;
  endtask

  task automatic commit(input logic [4:0] rd, input logic [3:0] idx, input logic [31:0] v);
    write_flag = 1'b1;
    write_rd   = rd;
    write_idx  = idx;
    new_val    = v;
  endtask

  initial begin
    idle();
    rdy = 1'b1;
    rst = 1'b1;
    rs1 = '0;
    rs2 = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    rs1 = 5'd5;
    rs2 = 5'd0;
    #1;
    chk("rst_rs1_busy", 32'(rs1_busy), 32'd0);
    chk("rst_rs1_val", rs1_val, 32'd0);
    chk("rst_rs2_busy", 32'(rs2_busy), 32'd0);
    chk("rst_rs2_val", rs2_val, 32'd0);

    // Rename x3 -> tag 7; same-cycle lookup sees old state
    rename(5'd3, 4'd7);
    rs1 = 5'd3;
    #1;
    chk("ren_same_cycle_busy", 32'(rs1_busy), 32'd0);
    tick();
    idle();
    #1;
    chk("ren_busy", 32'(rs1_busy), 32'd1);
    chk("ren_tag", 32'(rs1_tag), 32'd7);
    commit(5'd3, 4'd7, 32'hDEAD);
    #1;
    chk("byp_busy", 32'(rs1_busy), 32'd0);
    chk("byp_val", rs1_val, 32'hDEAD);
    tick();
    idle();
    #1;
    chk("cmt_state_busy", 32'(rs1_busy), 32'd0);
    chk("cmt_state_val", rs1_val, 32'hDEAD);

    // Older commit must not clear a younger writer's busy
    rename(5'd4, 4'd2);
    tick();
    rename(5'd4, 4'd5);
    tick();
    idle();
    commit(5'd4, 4'd2, 32'h11);
    rs2 = 5'd4;
    #1;
    chk("old_cmt_no_byp", 32'(rs2_busy), 32'd1);
    tick();
    idle();
    #1;
    chk("old_cmt_val", rs2_val, 32'h11);
    chk("old_cmt_busy", 32'(rs2_busy), 32'd1);
    chk("old_cmt_tag", 32'(rs2_tag), 32'd5);
    commit(5'd4, 4'd5, 32'h22);
    tick();
    idle();
    #1;
    chk("young_cmt_busy", 32'(rs2_busy), 32'd0);
    chk("young_cmt_val", rs2_val, 32'h22);

    // Same-cycle rename and commit on x6
    rename(5'd6, 4'd1);
    tick();
    idle();
    rename(5'd6, 4'd9);
    commit(5'd6, 4'd1, 32'h33);
    rs1 = 5'd6;
    #1;
    chk("rc_byp_busy", 32'(rs1_busy), 32'd0);
    chk("rc_byp_val", rs1_val, 32'h33);
    tick();
    idle();
    #1;
    chk("rc_busy", 32'(rs1_busy), 32'd1);
    chk("rc_tag", 32'(rs1_tag), 32'd9);
    chk("rc_val", rs1_val, 32'h33);

    // Flush with simultaneous rename and commit
    rename(5'd1, 4'd1);
    tick();
    rename(5'd2, 4'd2);
    tick();
    rename(5'd3, 4'd3);
    tick();
    idle();
    rs1 = 5'd2;
    #1;
    chk("pre_flush_busy", 32'(rs1_busy), 32'd1);
    flush = 1'b1;
    rename(5'd8, 4'd4);
    commit(5'd1, 4'd0, 32'h44);
    tick();
    idle();
    rs1 = 5'd1;
    rs2 = 5'd8;
    #1;
    chk("flush_x1_busy", 32'(rs1_busy), 32'd0);
    chk("flush_x1_val", rs1_val, 32'h44);
    chk("flush_x8_busy", 32'(rs2_busy), 32'd0);
    rs1 = 5'd2;
    rs2 = 5'd3;
    #1;
    chk("flush_x2_busy", 32'(rs1_busy), 32'd0);
    chk("flush_x3_busy", 32'(rs2_busy), 32'd0);

    // x0 is never written or renamed
    rename(5'd0, 4'd6);
    commit(5'd0, 4'd6, 32'h55);
    tick();
    idle();
    rs1 = 5'd0;
    #1;
    chk("x0_busy", 32'(rs1_busy), 32'd0);
    chk("x0_val", rs1_val, 32'd0);

    // rdy low freezes state
    rdy = 1'b0;
    rename(5'd9, 4'd3);
    commit(5'd1, 4'd0, 32'h66);
    tick();
    tick();
    idle();
    rdy = 1'b1;
    rs1 = 5'd9;
    rs2 = 5'd1;
    #1;
    chk("rdy0_x9_busy", 32'(rs1_busy), 32'd0);
    chk("rdy0_x1_val", rs2_val, 32'h44);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
